matmul_ctrl: RTL
================

# matmul_ctrl

Sequencing engine for the matrix-multiply datapath: computes C = A × B for square MAT_DIM×MAT_DIM signed integer matrices. It drives the read ports of the A and B operand BRAMs and the write port of the C result BRAM, all of which use combinational read and synchronous write. One dot product is accumulated per output element, and each result is written in row-major order. Software-side logic starts the block with a one-cycle `start` pulse and waits for `done`.

## Interface
- BRAM_ADDR_WIDTH, 6: address width of all three BRAMs.
- BRAM_DATA_WIDTH, 32: element width; two's-complement signed.
- MAT_DIM, 8: matrix dimension. Must be ≥2 and satisfy MAT_DIM*MAT_DIM ≤ 2**BRAM_ADDR_WIDTH.

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a multiply; sampled only in IDLE.
- busy  out  1  high from the cycle after `start` is accepted until `done` deasserts.
- done  out  1  one-cycle pulse after the last C write.
- a_rd_addr  out  BRAM_ADDR_WIDTH  A read address.
- a_dout  in  BRAM_DATA_WIDTH  A read data, valid in the same cycle as the address.
- b_rd_addr  out  BRAM_ADDR_WIDTH  B read address.
- b_dout  in  BRAM_DATA_WIDTH  B read data, valid in the same cycle as the address.
- c_wr_addr  out  BRAM_ADDR_WIDTH  C write address.
- c_wr_en  out  1  C write strobe.
- c_din  out  BRAM_DATA_WIDTH  C write data.

## Operation
- Storage is row-major: element (r,c) is at address r*MAT_DIM+c in every BRAM.
- Counters:
  - i is the row, j is the column, k is the inner index; each has width clog2(MAT_DIM).
  - acc is a signed accumulator, 2*BRAM_DATA_WIDTH+clog2(MAT_DIM) bits wide, so it cannot overflow.
- States and transitions:
  - IDLE: if `start`, clear i, j, k and acc, then go to COMPUTE. Otherwise stay in IDLE.
  - COMPUTE:
    - Outputs: a_rd_addr = i*MAT_DIM+k; b_rd_addr = k*MAT_DIM+j.
    - Each cycle, acc += signed(a_dout)*signed(b_dout).
    - If k==MAT_DIM-1, go to WRITE. Otherwise k++.
  - WRITE:
    - Outputs: c_wr_en=1; c_wr_addr=i*MAT_DIM+j; c_din=narrow(acc + the final product registered in COMPUTE).
    - Then clear acc and k.
    - If j<MAT_DIM-1: j++ and go to COMPUTE.
    - Else if i<MAT_DIM-1: j=0, i++ and go to COMPUTE.
    - Else go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Outputs c_wr_addr, c_wr_en and c_din are registered. In WRITE, acc already holds the complete sum.
- When not in COMPUTE, a_rd_addr and b_rd_addr hold their last value.
- `start` asserted in any state other than IDLE is ignored; it is not queued.
- `start` asserted in the DONE cycle is ignored. A new run requires `start` in IDLE.
- Reset mid-run:
  - The block returns to IDLE on the next edge.
  - No further writes occur.
  - C entries already written are left unchanged.
  - done is not asserted.
- narrow() is defined under Configuration.

## Timing
- Reset values:
  - busy=0, done=0, c_wr_en=0.
  - a_rd_addr=0, b_rd_addr=0, c_wr_addr=0, c_din=0.
  - State = IDLE.
- Latency per element is MAT_DIM COMPUTE cycles plus 1 WRITE cycle.
- If `start` is sampled at edge T, done is high in cycle T+1+MAT_DIM²·(MAT_DIM+1).
  - For defaults this is T+577.
- c_wr_en is high for exactly MAT_DIM² cycles per run, never in consecutive cycles.
- busy falls in the same cycle that done falls.
- The earliest next `start` accepted is in the cycle after done.

## Configuration
- MATMUL_SATURATE_EN.
  - Defined: narrow() clamps acc to [-2^(BRAM_DATA_WIDTH-1), 2^(BRAM_DATA_WIDTH-1)-1].
  - Undefined: narrow() takes acc[BRAM_DATA_WIDTH-1:0], i.e. wrap-around truncation.

## Test plan
- A=identity, B[r][c]=r*8+c → C equals B exactly. done is high at T+577 and c_wr_en pulses 64 times in addresses 0..63.
- A all 2, B all 3 → every C element is 48. A=all -1, B=all 5 → every C element is -40 (0xFFFFFFD8).
- A=B all 0x7FFFFFFF:
  - With MATMUL_SATURATE_EN → C all 0x7FFFFFFF.
  - Without it → C all 0x00000008.
- `start` is pulsed again at cycles T+10 and T+577 → there is exactly one run. busy stays high continuously, and there is no second done.
- reset is asserted after 20 C writes → c_wr_en is never seen high again and done never fires. Entries 0..19 hold the correct values, and entries 20..63 keep their prior contents. A following `start` completes the full run correctly.

Source files
------------

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: C = A x B for MAT_DIM x MAT_DIM signed matrices via combinational-read operand BRAMs.
// Latency: MAT_DIM+1 cycles per element; done pulses MAT_DIM^2*(MAT_DIM+1)+1 cycles after start.
// No backpressure; start ignored while busy. MATMUL_SATURATE_EN clamps results instead of wrapping.
module matmul_ctrl #(
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int MAT_DIM         = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [BRAM_ADDR_WIDTH-1:0] a_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] a_dout,
  output logic [BRAM_ADDR_WIDTH-1:0] b_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] b_dout,
  output logic [BRAM_ADDR_WIDTH-1:0] c_wr_addr,
  output logic                       c_wr_en,
  output logic [BRAM_DATA_WIDTH-1:0] c_din
);

  localparam int AW   = BRAM_ADDR_WIDTH;
  localparam int DW   = BRAM_DATA_WIDTH;
  localparam int CW   = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;
  localparam int ACCW = 2*DW + CW;
  localparam logic [CW-1:0] LAST  = CW'(MAT_DIM-1);
  localparam logic [AW-1:0] DIM_A = AW'(MAT_DIM);
`ifdef MATMUL_SATURATE_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_WRITE, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            i_q, j_q, k_q;
  logic signed [ACCW-1:0]   acc_q;
  logic signed [2*DW-1:0]   prod;
  logic                     start_ok, k_last, col_last, row_last;
  logic                     wr_nxt, done_nxt;
  logic [AW-1:0]            c_addr_nxt;
  logic [DW-1:0]            narrow_acc;

  // busy stays high through the done cycle, so a start there is dropped
  assign start_ok = start && !busy;
  assign k_last   = (k_q == LAST);
  assign col_last = (j_q == LAST);
  assign row_last = (i_q == LAST);
  assign prod     = $signed(a_dout) * $signed(b_dout);

  // counters only change in COMPUTE/WRITE, so the read addresses hold elsewhere
  assign a_rd_addr = AW'(i_q) * DIM_A + AW'(k_q);
  assign b_rd_addr = AW'(k_q) * DIM_A + AW'(j_q);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_ok) state_nxt = S_COMPUTE;
      S_COMPUTE: if (k_last) state_nxt = S_WRITE;
      S_WRITE:   state_nxt = (col_last && row_last) ? S_DONE : S_COMPUTE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr_nxt     = (state == S_WRITE);
    done_nxt   = (state == S_DONE);
    c_addr_nxt = AW'(i_q) * DIM_A + AW'(j_q);
`ifdef MATMUL_SATURATE_EN
    if (acc_q > SAT_MAX)      narrow_acc = {1'b0, {(DW-1){1'b1}}};
    else if (acc_q < SAT_MIN) narrow_acc = {1'b1, {(DW-1){1'b0}}};
    else                      narrow_acc = acc_q[DW-1:0];
`else
    narrow_acc = acc_q[DW-1:0];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      c_wr_en   <= 1'b0;
      c_wr_addr <= '0;
      c_din     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
    end else begin
      c_wr_en <= wr_nxt;
      done    <= done_nxt;
      if (wr_nxt) begin
        c_wr_addr <= c_addr_nxt;
        c_din     <= narrow_acc;
      end
      if (done) busy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            busy  <= 1'b1;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
          end
        end
        S_COMPUTE: begin
          acc_q <= acc_q + ACCW'(prod);
          if (!k_last) k_q <= k_q + CW'(1);
        end
        S_WRITE: begin
          // after the final element the counters are kept so the addresses hold
          if (!(col_last && row_last)) begin
            acc_q <= '0;
            k_q   <= '0;
            if (col_last) begin
              j_q <= '0;
              i_q <= i_q + CW'(1);
            end else begin
              j_q <= j_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
